// File: rtl/threshold_centroid_tracker_pkg.sv
// Shared definitions for the threshold centroid tracker: default widths and divider FSM states.
package threshold_centroid_tracker_pkg;

    localparam int DEFAULT_COORD_W    = 16;
    localparam int DEFAULT_CNT_W      = 20;
    localparam int DEFAULT_SUM_W      = 32;
    localparam int DEFAULT_MIN_PIXELS = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_DIV_X,
        ST_DIV_Y,
        ST_DONE
    } tracker_state_t;

endpackage

// File: rtl/threshold_centroid_tracker_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock. The start cycle already produces the
// first bit, so a full divide spans DIVIDEND_W edges and done pulses in the cycle after the last.
module threshold_centroid_tracker_seq_divider #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int ITER_W = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  rem_q, rem_d, div_q, div_d;
    logic [DIVISOR_W-1:0]  src_rem, src_div, rem_step;
    logic [DIVIDEND_W-1:0] quo_q, quo_d, src_quo, quo_step;
    logic [DIVISOR_W:0]    trial;
    logic [ITER_W-1:0]     iter_q, iter_d;
    logic                  busy_q, busy_d, done_q, done_d;

    // quo holds the not-yet-consumed dividend bits at the top and the quotient bits at the bottom
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_div = start ? divisor : div_q;
        trial   = {src_rem, src_quo[DIVIDEND_W-1]};
        if (trial >= {1'b0, src_div}) begin
            rem_step = DIVISOR_W'(trial - {1'b0, src_div});
            quo_step = {src_quo[DIVIDEND_W-2:0], 1'b1};
        end else begin
            rem_step = trial[DIVISOR_W-1:0];
            quo_step = {src_quo[DIVIDEND_W-2:0], 1'b0};
        end

        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        iter_d = iter_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = rem_step;
            quo_d  = quo_step;
            div_d  = divisor;
            iter_d = ITER_W'(DIVIDEND_W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = rem_step;
            quo_d  = quo_step;
            iter_d = iter_q - ITER_W'(1);
            if (iter_q == ITER_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/threshold_centroid_tracker.sv
// Per-frame foreground centroid of pixels brighter than the frame-start threshold.
// Define CENTROID_BBOX_EN to add the foreground bounding-box outputs.
module threshold_centroid_tracker
    import threshold_centroid_tracker_pkg::*;
#(
    parameter int COORD_W    = DEFAULT_COORD_W,
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int SUM_W      = DEFAULT_SUM_W,
    parameter int MIN_PIXELS = DEFAULT_MIN_PIXELS
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iFval,
    input  logic               iValid,
    input  logic [7:0]         iGray,
    input  logic [7:0]         iThreshold,
    input  logic [COORD_W-1:0] iX_Cont,
    input  logic [COORD_W-1:0] iY_Cont,
    output logic [COORD_W-1:0] oCentroidX,
    output logic [COORD_W-1:0] oCentroidY,
    output logic [CNT_W-1:0]   oPixelCount,
`ifdef CENTROID_BBOX_EN
    output logic [COORD_W-1:0] oMinX,
    output logic [COORD_W-1:0] oMaxX,
    output logic [COORD_W-1:0] oMinY,
    output logic [COORD_W-1:0] oMaxY,
`endif
    output logic               oEmpty,
    output logic               oDone,
    output logic               oBusy,
    output logic               oOverrun
);

    logic               fval_q, fval_rise, fval_fall, pixel_hit, below_min;
    logic [7:0]         thr_q, thr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [SUM_W:0]     sum_x_wide, sum_y_wide;

    tracker_state_t     state_q;
    logic [CNT_W-1:0]   sh_cnt_q, pixel_count_q;
    logic [SUM_W-1:0]   sh_sum_y_q;
    logic               empty_q, empty_out_q, done_q, overrun_q;
    logic [COORD_W-1:0] quot_x_q, centroid_x_q, centroid_y_q;

    logic               div_start, div_busy, div_done;
    logic [SUM_W-1:0]   div_dividend, div_quotient;
    logic [CNT_W-1:0]   div_divisor;

`ifdef CENTROID_BBOX_EN
    logic [COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d, min_y_q, min_y_d, max_y_q, max_y_d;
    logic [COORD_W-1:0] sh_min_x_q, sh_max_x_q, sh_min_y_q, sh_max_y_q;
    logic [COORD_W-1:0] out_min_x_q, out_max_x_q, out_min_y_q, out_max_y_q;
`endif

    function automatic logic [COORD_W-1:0] sat_coord(input logic [SUM_W-1:0] q);
        if (q > SUM_W'({COORD_W{1'b1}})) return '1;
        return q[COORD_W-1:0];
    endfunction

    // A frame-start clear takes priority over a pixel arriving on the same edge
    always_comb begin
        fval_rise  = iFval & ~fval_q;
        fval_fall  = ~iFval & fval_q;
        pixel_hit  = iFval & iValid & (iGray > thr_q);
        sum_x_wide = {1'b0, sum_x_q} + (SUM_W+1)'(iX_Cont);
        sum_y_wide = {1'b0, sum_y_q} + (SUM_W+1)'(iY_Cont);
        below_min  = cnt_q < CNT_W'(MIN_PIXELS);

        thr_d   = thr_q;
        cnt_d   = cnt_q;
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
`ifdef CENTROID_BBOX_EN
        min_x_d = min_x_q;
        max_x_d = max_x_q;
        min_y_d = min_y_q;
        max_y_d = max_y_q;
`endif
        if (fval_rise) begin
            thr_d   = iThreshold;
            cnt_d   = '0;
            sum_x_d = '0;
            sum_y_d = '0;
`ifdef CENTROID_BBOX_EN
            min_x_d = '1;
            max_x_d = '0;
            min_y_d = '1;
            max_y_d = '0;
`endif
        end else if (pixel_hit) begin
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            sum_x_d = sum_x_wide[SUM_W] ? '1 : sum_x_wide[SUM_W-1:0];
            sum_y_d = sum_y_wide[SUM_W] ? '1 : sum_y_wide[SUM_W-1:0];
`ifdef CENTROID_BBOX_EN
            if (iX_Cont < min_x_q) min_x_d = iX_Cont;
            if (iX_Cont > max_x_q) max_x_d = iX_Cont;
            if (iY_Cont < min_y_q) min_y_d = iY_Cont;
            if (iY_Cont > max_y_q) max_y_d = iY_Cont;
`endif
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            fval_q  <= 1'b0;
            thr_q   <= '0;
            cnt_q   <= '0;
            sum_x_q <= '0;
            sum_y_q <= '0;
`ifdef CENTROID_BBOX_EN
            min_x_q <= '0;
            max_x_q <= '0;
            min_y_q <= '0;
            max_y_q <= '0;
`endif
        end else begin
            fval_q  <= iFval;
            thr_q   <= thr_d;
            cnt_q   <= cnt_d;
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
`ifdef CENTROID_BBOX_EN
            min_x_q <= min_x_d;
            max_x_q <= max_x_d;
            min_y_q <= min_y_d;
            max_y_q <= max_y_d;
`endif
        end
    end

    // X divide launches straight from the live sums in LATCH; Y follows from the shadow copy
    assign div_start    = ((state_q == ST_LATCH) & ~below_min) | ((state_q == ST_DIV_X) & div_done);
    assign div_dividend = (state_q == ST_LATCH) ? sum_x_q : sh_sum_y_q;
    assign div_divisor  = (state_q == ST_LATCH) ? cnt_q : sh_cnt_q;

    threshold_centroid_tracker_seq_divider #(
        .DIVIDEND_W(SUM_W),
        .DIVISOR_W (CNT_W)
    ) u_divider (
        .clk     (iClk),
        .rst_n   (iRst_n),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (div_divisor),
        .busy    (div_busy),
        .done    (div_done),
        .quotient(div_quotient)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q       <= ST_IDLE;
            sh_cnt_q      <= '0;
            sh_sum_y_q    <= '0;
            empty_q       <= 1'b0;
            quot_x_q      <= '0;
            centroid_x_q  <= '0;
            centroid_y_q  <= '0;
            pixel_count_q <= '0;
            empty_out_q   <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef CENTROID_BBOX_EN
            sh_min_x_q    <= '0;
            sh_max_x_q    <= '0;
            sh_min_y_q    <= '0;
            sh_max_y_q    <= '0;
            out_min_x_q   <= '0;
            out_max_x_q   <= '0;
            out_min_y_q   <= '0;
            out_max_y_q   <= '0;
`endif
        end else begin
            done_q    <= 1'b0;
            overrun_q <= fval_fall & (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (fval_fall) state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    sh_cnt_q   <= cnt_q;
                    sh_sum_y_q <= sum_y_q;
                    empty_q    <= below_min;
`ifdef CENTROID_BBOX_EN
                    sh_min_x_q <= min_x_q;
                    sh_max_x_q <= max_x_q;
                    sh_min_y_q <= min_y_q;
                    sh_max_y_q <= max_y_q;
`endif
                    state_q    <= below_min ? ST_DONE : ST_DIV_X;
                end
                ST_DIV_X: begin
                    if (div_done) begin
                        quot_x_q <= sat_coord(div_quotient);
                        state_q  <= ST_DIV_Y;
                    end
                end
                ST_DIV_Y: begin
                    if (div_done) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    pixel_count_q <= sh_cnt_q;
                    empty_out_q   <= empty_q;
                    centroid_x_q  <= empty_q ? '0 : quot_x_q;
                    centroid_y_q  <= empty_q ? '0 : sat_coord(div_quotient);
`ifdef CENTROID_BBOX_EN
                    out_min_x_q   <= empty_q ? '0 : sh_min_x_q;
                    out_max_x_q   <= empty_q ? '0 : sh_max_x_q;
                    out_min_y_q   <= empty_q ? '0 : sh_min_y_q;
                    out_max_y_q   <= empty_q ? '0 : sh_max_y_q;
`endif
                    done_q        <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oCentroidX  = centroid_x_q;
    assign oCentroidY  = centroid_y_q;
    assign oPixelCount = pixel_count_q;
    assign oEmpty      = empty_out_q;
    assign oDone       = done_q;
    assign oBusy       = (state_q != ST_IDLE) | div_busy;
    assign oOverrun    = overrun_q;
`ifdef CENTROID_BBOX_EN
    assign oMinX = out_min_x_q;
    assign oMaxX = out_max_x_q;
    assign oMinY = out_min_y_q;
    assign oMaxY = out_max_y_q;
`endif

endmodule

// File: tb/tb_threshold_centroid_tracker.sv
// Bench for threshold_centroid_tracker: drives whole frames and compares each frame's result
// with a frame-level arithmetic model of count, coordinate sums and averages.
module tb_threshold_centroid_tracker;

    localparam int COORD_W   = 16;
    localparam int CNT_W     = 20;
    localparam int SUM_W     = 32;
    localparam int MIN_PIX   = 8;
    localparam int LAT_FULL  = 2 * SUM_W + 2;
    localparam int LAT_EMPTY = 2;

    logic               iClk, iRst_n, iFval, iValid;
    logic [7:0]         iGray, iThreshold;
    logic [COORD_W-1:0] iX_Cont, iY_Cont;
    logic [COORD_W-1:0] oCentroidX, oCentroidY;
    logic [CNT_W-1:0]   oPixelCount;
    logic               oEmpty, oDone, oBusy, oOverrun;
`ifdef CENTROID_BBOX_EN
    logic [COORD_W-1:0] oMinX, oMaxX, oMinY, oMaxY;
`endif

    threshold_centroid_tracker #(
        .COORD_W   (COORD_W),
        .CNT_W     (CNT_W),
        .SUM_W     (SUM_W),
        .MIN_PIXELS(MIN_PIX)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iFval      (iFval),
        .iValid     (iValid),
        .iGray      (iGray),
        .iThreshold (iThreshold),
        .iX_Cont    (iX_Cont),
        .iY_Cont    (iY_Cont),
        .oCentroidX (oCentroidX),
        .oCentroidY (oCentroidY),
        .oPixelCount(oPixelCount),
`ifdef CENTROID_BBOX_EN
        .oMinX      (oMinX),
        .oMaxX      (oMaxX),
        .oMinY      (oMinY),
        .oMaxY      (oMaxY),
`endif
        .oEmpty     (oEmpty),
        .oDone      (oDone),
        .oBusy      (oBusy),
        .oOverrun   (oOverrun)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_fail   = 0;

    longint m_cnt, m_sx, m_sy;
    int     m_minx, m_maxx, m_miny, m_maxy;
    int     exp_cnt, exp_cx, exp_cy, exp_empty;
    int     exp_minx, exp_maxx, exp_miny, exp_maxy;
    int     done_lat, done_cnt, ovr_cnt, ovr_at, busy_seen, busy_end;

    // mode 0: random gray, 1: 4x4 block of 200 at (10..13, 20..23), 2: all 100, 3: all 200
    task automatic drive_frame(input int mode, input int thr, input int thr_late,
                               input int x0, input int y0, input int w, input int h);
        int g;
        m_cnt = 0; m_sx = 0; m_sy = 0;
        m_minx = 65535; m_maxx = 0; m_miny = 65535; m_maxy = 0;
        @(posedge iClk); #1;
        iFval = 1'b1; iThreshold = 8'(thr);
        iValid = 1'b1; iGray = 8'd255; iX_Cont = 16'(x0); iY_Cont = 16'(y0);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(posedge iClk); #1;
                    iValid = 1'b0; iGray = 8'($urandom_range(0, 255));
                end
                @(posedge iClk); #1;
                if (y * w + x == (w * h) / 2) iThreshold = 8'(thr_late);
                case (mode)
                    1: g = (x >= 10 && x <= 13 && y >= 20 && y <= 23) ? 200 : 0;
                    2: g = 100;
                    3: g = 200;
                    default: g = $urandom_range(0, 255);
                endcase
                iValid = 1'b1; iGray = 8'(g);
                iX_Cont = 16'(x0 + x); iY_Cont = 16'(y0 + y);
                if (g > thr) begin
                    m_cnt++; m_sx += x0 + x; m_sy += y0 + y;
                    if (x0 + x < m_minx) m_minx = x0 + x;
                    if (x0 + x > m_maxx) m_maxx = x0 + x;
                    if (y0 + y < m_miny) m_miny = y0 + y;
                    if (y0 + y > m_maxy) m_maxy = y0 + y;
                end
            end
        end
        @(posedge iClk); #1;
        iValid = 1'b0; iFval = 1'b0;
        exp_cnt = int'(m_cnt);
        if (m_cnt < MIN_PIX) begin
            exp_empty = 1; exp_cx = 0; exp_cy = 0;
            exp_minx = 0; exp_maxx = 0; exp_miny = 0; exp_maxy = 0;
        end else begin
            exp_empty = 0;
            exp_cx = (m_sx / m_cnt > 65535) ? 65535 : int'(m_sx / m_cnt);
            exp_cy = (m_sy / m_cnt > 65535) ? 65535 : int'(m_sy / m_cnt);
            exp_minx = m_minx; exp_maxx = m_maxx; exp_miny = m_miny; exp_maxy = m_maxy;
        end
    endtask

    // Watches a fixed window after the frame-end edge; optionally injects a second frame end
    task automatic watch_frame_end(input int inject_at);
        @(posedge iClk);
        done_lat = -1; done_cnt = 0; ovr_cnt = 0; ovr_at = -1; busy_seen = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge iClk); #1;
            if (oDone === 1'b1) begin done_cnt++; if (done_lat < 0) done_lat = k; end
            if (oOverrun === 1'b1) begin ovr_cnt++; if (ovr_at < 0) ovr_at = k; end
            if (k == 1) busy_seen = int'(oBusy);
            if (inject_at > 0 && k == inject_at - 2) iFval = 1'b1;
            if (inject_at > 0 && k == inject_at - 1) iFval = 1'b0;
        end
        busy_end = int'(oBusy);
    endtask

    task automatic test_reset();
        iRst_n = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        n_checks++;
        if ({oCentroidX, oCentroidY, oPixelCount, oEmpty, oDone, oBusy, oOverrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cx=%0d cy=%0d cnt=%0d empty=%b done=%b busy=%b ovr=%b, expected all 0",
                     oCentroidX, oCentroidY, oPixelCount, oEmpty, oDone, oBusy, oOverrun);
        end
        iRst_n = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        n_checks++;
        if (oBusy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", oBusy);
        end
    endtask

    task automatic test_block_centroid();
        drive_frame(1, 100, 100, 0, 0, 16, 26);
        watch_frame_end(0);
        n_checks++;
        if (done_lat != LAT_FULL || done_cnt != 1) begin
            n_fail++; $display("FAIL block_latency: got lat=%0d pulses=%0d expected lat=%0d pulses=1", done_lat, done_cnt, LAT_FULL);
        end
        n_checks++;
        if (oCentroidX !== 16'(exp_cx) || oCentroidY !== 16'(exp_cy) || exp_cx != 11 || exp_cy != 21) begin
            n_fail++; $display("FAIL block_centroid: got (%0d,%0d) expected (%0d,%0d)", oCentroidX, oCentroidY, exp_cx, exp_cy);
        end
        n_checks++;
        if (oPixelCount !== CNT_W'(exp_cnt) || oEmpty !== 1'b0) begin
            n_fail++; $display("FAIL block_count: got cnt=%0d empty=%b expected cnt=%0d empty=0", oPixelCount, oEmpty, exp_cnt);
        end
        n_checks++;
        if (busy_seen != 1 || busy_end != 0) begin
            n_fail++; $display("FAIL block_busy: got during=%0d after=%0d expected 1/0", busy_seen, busy_end);
        end
`ifdef CENTROID_BBOX_EN
        n_checks++;
        if (oMinX !== 16'd10 || oMaxX !== 16'd13 || oMinY !== 16'd20 || oMaxY !== 16'd23) begin
            n_fail++; $display("FAIL block_bbox: got x %0d..%0d y %0d..%0d expected x 10..13 y 20..23", oMinX, oMaxX, oMinY, oMaxY);
        end
`endif
    endtask

    task automatic test_equal_threshold();
        drive_frame(2, 100, 100, 5, 5, 10, 6);
        watch_frame_end(0);
        n_checks++;
        if (done_lat != LAT_EMPTY || done_cnt != 1) begin
            n_fail++; $display("FAIL equal_latency: got lat=%0d pulses=%0d expected lat=%0d pulses=1", done_lat, done_cnt, LAT_EMPTY);
        end
        n_checks++;
        if (oPixelCount !== '0 || oEmpty !== 1'b1 || oCentroidX !== '0 || oCentroidY !== '0) begin
            n_fail++; $display("FAIL equal_empty: got cnt=%0d empty=%b cx=%0d cy=%0d expected 0/1/0/0", oPixelCount, oEmpty, oCentroidX, oCentroidY);
        end
`ifdef CENTROID_BBOX_EN
        n_checks++;
        if ({oMinX, oMaxX, oMinY, oMaxY} !== '0) begin
            n_fail++; $display("FAIL equal_bbox: got x %0d..%0d y %0d..%0d expected all 0", oMinX, oMaxX, oMinY, oMaxY);
        end
`endif
    endtask

    task automatic test_threshold_change();
        drive_frame(3, 100, 250, 30, 40, 8, 4);
        watch_frame_end(0);
        n_checks++;
        if (oPixelCount !== CNT_W'(exp_cnt) || exp_cnt != 32 || oEmpty !== 1'b0) begin
            n_fail++; $display("FAIL thr_midframe_count: got cnt=%0d empty=%b expected cnt=%0d empty=0", oPixelCount, oEmpty, exp_cnt);
        end
        n_checks++;
        if (oCentroidX !== 16'(exp_cx) || oCentroidY !== 16'(exp_cy)) begin
            n_fail++; $display("FAIL thr_midframe_centroid: got (%0d,%0d) expected (%0d,%0d)", oCentroidX, oCentroidY, exp_cx, exp_cy);
        end
        drive_frame(3, 250, 250, 30, 40, 8, 4);
        watch_frame_end(0);
        n_checks++;
        if (oPixelCount !== '0 || oEmpty !== 1'b1 || done_lat != LAT_EMPTY) begin
            n_fail++; $display("FAIL thr_next_frame: got cnt=%0d empty=%b lat=%0d expected cnt=0 empty=1 lat=%0d", oPixelCount, oEmpty, done_lat, LAT_EMPTY);
        end
    endtask

    task automatic test_overrun();
        drive_frame(1, 100, 100, 0, 0, 16, 26);
        watch_frame_end(10);
        n_checks++;
        if (ovr_cnt != 1 || ovr_at != 10) begin
            n_fail++; $display("FAIL overrun_pulse: got pulses=%0d at=%0d expected pulses=1 at=10", ovr_cnt, ovr_at);
        end
        n_checks++;
        if (done_cnt != 1 || done_lat != LAT_FULL) begin
            n_fail++; $display("FAIL overrun_done: got pulses=%0d lat=%0d expected pulses=1 lat=%0d", done_cnt, done_lat, LAT_FULL);
        end
        n_checks++;
        if (oCentroidX !== 16'(exp_cx) || oCentroidY !== 16'(exp_cy) || oPixelCount !== CNT_W'(exp_cnt) || oEmpty !== 1'b0) begin
            n_fail++; $display("FAIL overrun_outputs: got (%0d,%0d) cnt=%0d empty=%b expected (%0d,%0d) cnt=%0d empty=0",
                               oCentroidX, oCentroidY, oPixelCount, oEmpty, exp_cx, exp_cy, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_div();
        int dones;
        drive_frame(0, 20, 20, 100, 200, 12, 8);
        @(posedge iClk);
        repeat (SUM_W + 10) @(posedge iClk);
        #1;
        iRst_n = 1'b0;
        #1;
        n_checks++;
        if ({oCentroidX, oCentroidY, oPixelCount, oEmpty, oDone, oBusy} !== '0) begin
            n_fail++; $display("FAIL middiv_reset: got cx=%0d cy=%0d cnt=%0d empty=%b done=%b busy=%b expected all 0",
                               oCentroidX, oCentroidY, oPixelCount, oEmpty, oDone, oBusy);
        end
        repeat (2) @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge iClk); #1;
            if (oDone === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0 || oBusy !== 1'b0) begin
            n_fail++; $display("FAIL middiv_no_done: got pulses=%0d busy=%b expected 0/0", dones, oBusy);
        end
        drive_frame(0, 30, 30, 1000, 2000, 10, 6);
        watch_frame_end(0);
        n_checks++;
        if (oCentroidX !== 16'(exp_cx) || oCentroidY !== 16'(exp_cy) || oPixelCount !== CNT_W'(exp_cnt) || oEmpty !== 1'(exp_empty)) begin
            n_fail++; $display("FAIL middiv_recover: got (%0d,%0d) cnt=%0d empty=%b expected (%0d,%0d) cnt=%0d empty=%0d",
                               oCentroidX, oCentroidY, oPixelCount, oEmpty, exp_cx, exp_cy, exp_cnt, exp_empty);
        end
    endtask

    task automatic test_random_frames();
        int thr, lat_exp;
        for (int f = 0; f < 6; f++) begin
            thr = $urandom_range(0, 230);
            drive_frame(0, thr, $urandom_range(0, 255), $urandom_range(0, 65000), $urandom_range(0, 65000),
                        $urandom_range(4, 12), $urandom_range(2, 8));
            watch_frame_end(0);
            lat_exp = exp_empty ? LAT_EMPTY : LAT_FULL;
            n_checks++;
            if (done_lat != lat_exp || done_cnt != 1 || ovr_cnt != 0) begin
                n_fail++; $display("FAIL random_timing[%0d]: got lat=%0d pulses=%0d ovr=%0d expected lat=%0d pulses=1 ovr=0",
                                   f, done_lat, done_cnt, ovr_cnt, lat_exp);
            end
            n_checks++;
            if (oCentroidX !== 16'(exp_cx) || oCentroidY !== 16'(exp_cy) || oPixelCount !== CNT_W'(exp_cnt) || oEmpty !== 1'(exp_empty)) begin
                n_fail++; $display("FAIL random_result[%0d]: got (%0d,%0d) cnt=%0d empty=%b expected (%0d,%0d) cnt=%0d empty=%0d",
                                   f, oCentroidX, oCentroidY, oPixelCount, oEmpty, exp_cx, exp_cy, exp_cnt, exp_empty);
            end
`ifdef CENTROID_BBOX_EN
            n_checks++;
            if (oMinX !== 16'(exp_minx) || oMaxX !== 16'(exp_maxx) || oMinY !== 16'(exp_miny) || oMaxY !== 16'(exp_maxy)) begin
                n_fail++; $display("FAIL random_bbox[%0d]: got x %0d..%0d y %0d..%0d expected x %0d..%0d y %0d..%0d",
                                   f, oMinX, oMaxX, oMinY, oMaxY, exp_minx, exp_maxx, exp_miny, exp_maxy);
            end
`endif
        end
    endtask

    initial begin
        iRst_n = 1'b0; iFval = 1'b0; iValid = 1'b0; iGray = '0;
        iThreshold = '0; iX_Cont = '0; iY_Cont = '0;
        test_reset();
        test_block_centroid();
        test_equal_threshold();
        test_threshold_change();
        test_overrun();
        test_reset_mid_div();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
